// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_t;
  localparam int unsigned INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/ready and decode valid/ready handshake bundle.
interface fetch_controller_if #(parameter int unsigned REG_BITS = 32) ();
  logic                imemReq;
  logic [REG_BITS-1:0] imemAddr;
  logic                imemReady;
  logic [REG_BITS-1:0] imemRdata;
  logic                instrValid;
  logic [REG_BITS-1:0] instr;
  logic [REG_BITS-1:0] instrPc;
  logic                decodeReady;

  modport master (
    output imemReq, imemAddr, instrValid, instr, instrPc,
    input  imemReady, imemRdata, decodeReady
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instr, instrPc,
    output imemReady, imemRdata, decodeReady
  );
endinterface

// File: rtl/fetch_controller_buffer.sv
// Holding register for the fetched instruction word and its address.
module fetch_buffer #(
  parameter int unsigned REG_BITS = 32
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                load,
  input  logic [REG_BITS-1:0] rdata,
  input  logic [REG_BITS-1:0] addr,
  output logic [REG_BITS-1:0] instr,
  output logic [REG_BITS-1:0] instrPc
);
  always_ff @(posedge clk) begin
    if (clear) begin
      instr   <= '0;
      instrPc <= '0;
    end else if (load) begin
      instr   <= rdata;
      instrPc <= addr;
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: drives pcNext, the instruction-memory request and the decode handshake.
module fetch_controller
  import riscv_pkg::*;
#(
  parameter int unsigned         REG_BITS     = 32,
  parameter logic [REG_BITS-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] pc,
  output logic [REG_BITS-1:0] pcNext,
  fetch_controller_if.master  bus,
  input  logic                redirectValid,
  input  logic [REG_BITS-1:0] redirectTarget,
  input  logic                stall,
  output logic                misaligned
);
  fetch_state_t        state;
  logic [REG_BITS-1:0] reqAddr;
  logic [REG_BITS-1:0] redirectPc;
  logic                accept;
  logic                capture;

  assign redirectPc = {redirectTarget[REG_BITS-1:2], 2'b00};
  assign accept     = (state == HOLD) && bus.decodeReady && !redirectValid;
  assign capture    = (state == REQ) && bus.imemReady && !redirectValid && !rst;

  always_comb begin
    pcNext = pc;
    if (rst)                pcNext = RESET_VECTOR;
    else if (redirectValid) pcNext = redirectPc;
    else if (accept)        pcNext = pc + REG_BITS'(INSTR_BYTES);
  end

  assign misaligned     = !rst && redirectValid && (|redirectTarget[1:0]);
  // Reset aborts an in-flight request in the same cycle, so gate the decodes with rst.
  assign bus.imemReq    = !rst && ((state == REQ) || (state == DRAIN));
  assign bus.instrValid = !rst && (state == HOLD);
  assign bus.imemAddr   = reqAddr;

  // reqAddr takes pcNext at the transition edge: that is the pc value seen on entry to REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      reqAddr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!stall) begin
            state   <= REQ;
            reqAddr <= pcNext;
          end
        end
        REQ: begin
          if (redirectValid && !bus.imemReady) begin
            state <= DRAIN;
          end else if (redirectValid) begin
            if (stall) state <= IDLE;
            else begin
              state   <= REQ;
              reqAddr <= pcNext;
            end
          end else if (bus.imemReady) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (redirectValid || bus.decodeReady) begin
            if (stall) state <= IDLE;
            else begin
              state   <= REQ;
              reqAddr <= pcNext;
            end
          end
        end
        DRAIN: begin
          if (bus.imemReady) begin
            if (stall) state <= IDLE;
            else begin
              state   <= REQ;
              reqAddr <= pcNext;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_buffer #(.REG_BITS(REG_BITS)) u_buffer (
    .clk     (clk),
    .clear   (rst),
    .load    (capture),
    .rdata   (bus.imemRdata),
    .addr    (reqAddr),
    .instr   (bus.instr),
    .instrPc (bus.instrPc)
  );
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch around the ProgramCounter register. Each cycle it computes `pcNext` from sequential advance, branch/jump redirect, or stall. It runs the request/ready handshake to instruction memory and presents fetched instructions to decode under a valid/ready handshake. It sits between ProgramCounter, instruction memory and the decode stage. It is the only writer of `pcNext`.

## Interface
Parameters:
- `REG_BITS`, default 32: address and instruction width.
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`, in, 1: sole clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `pc`, in, REG_BITS: current value from ProgramCounter.
- `pcNext`, out, REG_BITS: next PC; ProgramCounter loads it every rising edge.
- `imemReq`, out, 1: fetch request.
- `imemAddr`, out, REG_BITS: fetch address; stable while `imemReq` is high.
- `imemReady`, in, 1: memory accepts the request and returns `imemRdata` in the same cycle.
- `imemRdata`, in, REG_BITS: fetched instruction word.
- `instrValid`, out, 1: instruction is available to decode.
- `instr`, out, REG_BITS: instruction to decode.
- `instrPc`, out, REG_BITS: address of `instr`.
- `decodeReady`, in, 1: decode consumes `instr` when this and `instrValid` are both high.
- `redirectValid`, in, 1: single-cycle taken branch/jump pulse.
- `redirectTarget`, in, REG_BITS: redirect address.
- `stall`, in, 1: hazard unit hold request.
- `misaligned`, out, 1: one-cycle pulse when a redirect target has bits [1:0] ≠ 0.

## Operation
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE:
  - `imemReq`=0.
  - Goes to REQ on the next cycle when `stall`=0.
- REQ:
  - `imemReq`=1 and `imemAddr`=`reqAddr`. `reqAddr` is an internal register loaded from `pc` on entry.
  - On `imemReady`, capture `imemRdata` into `instr` and `reqAddr` into `instrPc`, then go to HOLD.
- HOLD:
  - `instrValid`=1.
  - On accept (`decodeReady`=1): `pcNext`=`pc`+4 (modulo 2^REG_BITS, no overflow flag). Go to REQ, or to IDLE if `stall`=1.
- Redirect (`redirectValid`=1) has the highest priority in every state:
  - `pcNext` = {`redirectTarget`[REG_BITS-1:2], 2'b00}.
  - `misaligned` = |`redirectTarget`[1:0] in the same cycle.
  - In HOLD, the held instruction is dropped: no accept occurs and `instrValid` falls next cycle.
  - In REQ with `imemReady`=0, go to DRAIN. Otherwise go to REQ (or IDLE if `stall`).
- DRAIN:
  - `imemReq` stays 1 with the unchanged `imemAddr`; an issued request is never retracted.
  - When `imemReady` arrives, the response is discarded and the state goes to REQ at the redirected `pc`.
  - A second redirect while in DRAIN updates `pcNext` again and stays in DRAIN.
- `stall`=1 without a redirect:
  - `pcNext`=`pc`.
  - No new request starts from IDLE or from a HOLD accept.
  - An outstanding REQ completes into HOLD.
  - HOLD keeps `instrValid`. Decode is responsible for not asserting `decodeReady` while stalled.
- Otherwise `pcNext`=`pc`.

## Timing
- During `rst`:
  - `pcNext`=RESET_VECTOR.
  - `imemReq`=0, `instrValid`=0, `misaligned`=0.
  - `instr`=0, `instrPc`=0, state=IDLE.
- Reset asserted mid-fetch aborts immediately; any later `imemReady` is ignored.
- First release cycle: IDLE. First `imemReq` appears one cycle later with `imemAddr`=RESET_VECTOR.
- Fetch latency:
  - `instrValid` rises one cycle after the `imemReady` cycle.
  - With zero-wait memory and decode always ready, throughput is one instruction per 2 cycles.
- Redirect to first request with the new address: 1 cycle when not in DRAIN; otherwise 1 cycle after the drained `imemReady`.
- `misaligned` is combinational with `redirectValid`.
- All other outputs are registered or decoded from state.

## Structure
- Package `riscv_pkg`:
  - `fetch_state_t` enum (IDLE, REQ, HOLD, DRAIN).
  - `INSTR_BYTES`=4.
- Single module. The instruction/`instrPc` holding register may be split into a sub-module `fetch_buffer` (load enable, clear), instantiated once.

## Test plan
- Reset release, RESET_VECTOR=32'h100, `imemReady` tied 1, decode always ready → `imemAddr` sequence 100, 104, 108, one instruction per 2 cycles, `instrPc` matching.
- `imemReady` low for 3 cycles on 32'h104 → `imemReq` and `imemAddr` stable for 4 cycles, then `instr`=`imemRdata` sampled in the ready cycle.
- Redirect to 32'h200 while in HOLD with `instrPc`=32'h108 → 108 never accepted, next `imemAddr`=32'h200.
- Redirect to 32'h300 during a 2-cycle-outstanding request → DRAIN, response discarded, `instrValid` stays 0, next request 32'h300.
- `stall` held 4 cycles in IDLE/HOLD → `pcNext`=`pc`, no new `imemReq`. Redirect to 32'h402 during the stall → `pcNext`=32'h400, `misaligned` pulses once.
- Mid-fetch `rst` with `imemReady` arriving in the following cycle → all outputs at reset values, response ignored, restart at RESET_VECTOR.
